spi_frame_arbiter: RTL and testbench
====================================

Name: spi_frame_arbiter

Overview:
- Shares one SPI master engine between NUM_REQ requesters.
- Round-robin grant per frame (one CS-low window of BYTE_COUNT bytes).
- Sequences the master: start pulse, per-byte TX reload, per-byte RX capture, inter-frame gap.
- Sits between requester clients (flash, ADC, config regs) and the single SPI master instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- BYTE_COUNT, 5: bytes per frame; must equal the master's byte-count setting.
- GAP_CYCLES, 3: idle i_clk cycles between frames; minimum 2 (master DONE→IDLE recovery).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  NUM_REQ  level request per requester; held until its o_frame_done
- i_tx_data  in  NUM_REQ*8  per-requester next TX byte; slice k = [8k+7:8k]
- o_gnt  out  NUM_REQ  one-hot grant, held for the whole frame
- o_tx_ack  out  1  pulse: granted requester's current byte latched; present next byte next cycle
- o_rx_valid  out  1  pulse: o_rx_data holds a received byte
- o_rx_data  out  8  received byte, broadcast, meaningful to grantee only
- o_frame_done  out  NUM_REQ  one-hot pulse at frame end
- o_busy  out  1  high from grant until end of gap
- o_spi_tx_dv  out  1  start pulse to master
- o_spi_tx_data  out  8  registered TX byte to master
- i_spi_done  in  1  master pre-boundary strobe (one cycle before each byte boundary)
- i_spi_bytedone  in  1  master byte-complete pulse
- i_spi_rx_data  in  8  master RX byte; valid the cycle after i_spi_bytedone

Behaviour:
- Reset: all outputs 0; state ARB_IDLE; RR pointer = 0; byte counter = 0.
- States: ARB_IDLE, ARB_START, ARB_XFER, ARB_LAST_RX, ARB_GAP.
- ARB_IDLE: if any i_req, pick first set bit at or after RR pointer (wrap-around), register o_gnt, latch that requester's i_tx_data into o_spi_tx_data, pulse o_tx_ack, go ARB_START. No request → stay.
- ARB_START: o_spi_tx_dv = 1 for exactly one cycle; go ARB_XFER.
- ARB_XFER:
  - i_spi_done while byte counter < BYTE_COUNT-1: reload o_spi_tx_data from the grantee's slice and pulse o_tx_ack. The reload is visible before the master's byte boundary.
  - i_spi_bytedone: counter++. Next cycle: o_rx_data ← i_spi_rx_data, o_rx_valid pulses.
  - bytedone while counter == BYTE_COUNT-1 → ARB_LAST_RX.
- ARB_LAST_RX: capture final RX byte, pulse o_rx_valid and o_frame_done[grant]; RR pointer ← grant index + 1 (mod NUM_REQ); clear o_gnt; go ARB_GAP.
- ARB_GAP: count GAP_CYCLES, then ARB_IDLE. o_busy falls on entry to ARB_IDLE.
- Latencies:
  - Request to o_spi_tx_dv: 2 cycles.
  - Last bytedone to o_frame_done: 1 cycle.
- Edge cases:
  - i_req dropped mid-frame: the frame still completes (master cannot abort); the grantee receives done.
  - i_spi_done and i_spi_bytedone in the same cycle: both handled independently.
  - Spurious i_spi_bytedone outside ARB_XFER: ignored.
  - Exactly BYTE_COUNT o_tx_ack and BYTE_COUNT o_rx_valid pulses per frame.
  - i_rst mid-frame: immediate return to reset values; the master is reset by the same i_rst.

Optional Feature:
- Macro SPI_ARB_FIXED_PRIO_EN.
- Defined: grant goes to the lowest-index asserted request; RR pointer is unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package spi_pkg holds:
  - arb_state_t enum
  - constant SPI_BYTE_W = 8
  - function onehot_to_idx
- One sub-module: spi_rr_picker. Combinational; inputs i_req and pointer; outputs one-hot winner. The fixed-priority variant lives inside it under the macro.

Test Plan:
- Single requester, NUM_REQ=4, BYTE_COUNT=5: req[2], TX bytes A5,3C,FF,00,81 → one tx_dv, 5 tx_acks, master MOSI stream matches, 5 rx_valid, frame_done[2]=1.
- All four requesting continuously → grant order 0,1,2,3,0. With SPI_ARB_FIXED_PRIO_EN: 0,0,0.
- Loopback MISO=MOSI → each o_rx_data equals the corresponding TX byte.
- Gap check: back-to-back frames with GAP_CYCLES=3 → exactly 3 idle cycles after frame_done before the next tx_dv.
- i_req[1] dropped after byte 2 → frame still delivers 5 bytes and frame_done[1].
- i_rst asserted during byte 3 → outputs 0 within the reset cycle; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI frame arbiter.
//   arb_state_t   : arbiter FSM states
//   SPI_BYTE_W    : SPI byte width
//   onehot_to_idx : index of the set bit in a one-hot vector of up to 8 bits
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_START,
    ARB_XFER,
    ARB_LAST_RX,
    ARB_GAP
  } arb_state_t;
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) onehot_to_idx = 3'(i);
  endfunction
endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational winner selection among NUM_REQ requests.
//   req_i : request vector
//   ptr_i : round-robin start index (search begins here, wraps around)
//   gnt_o : one-hot winner, zero when no request
// Build option SPI_ARB_FIXED_PRIO_EN: lowest-index request wins, ptr_i ignored.
module spi_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);
`ifdef SPI_ARB_FIXED_PRIO_EN
  assign gnt_o = req_i & (~req_i + NUM_REQ'(1));
`else
  logic [NUM_REQ-1:0] hi, cand;
  // Prefer requests at or above the pointer; fall back to the full vector
  // for the wrap-around, then isolate the lowest set bit.
  always_comb begin
    hi    = req_i & ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
    cand  = (|hi) ? hi : req_i;
    gnt_o = cand & (~cand + NUM_REQ'(1));
  end
`endif
endmodule

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: shares one SPI master between NUM_REQ requesters, one
// BYTE_COUNT-byte frame per grant, round-robin, with GAP_CYCLES idle cycles
// between frames.
//   i_req/i_tx_data          : requester side (per-requester level request, TX byte)
//   o_gnt/o_tx_ack           : grant and "byte latched" handshake
//   o_rx_valid/o_rx_data     : received byte broadcast
//   o_frame_done/o_busy      : per-requester frame end pulse, arbiter activity
//   o_spi_tx_dv/o_spi_tx_data: start pulse and TX byte to the master
//   i_spi_done/i_spi_bytedone/i_spi_rx_data : master status and RX byte
// Build option SPI_ARB_FIXED_PRIO_EN: fixed lowest-index priority (in spi_rr_picker).
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BYTE_COUNT = 5,
  parameter int GAP_CYCLES = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*SPI_BYTE_W-1:0] i_tx_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_tx_ack,
  output logic                          o_rx_valid,
  output logic [SPI_BYTE_W-1:0]         o_rx_data,
  output logic [NUM_REQ-1:0]            o_frame_done,
  output logic                          o_busy,
  output logic                          o_spi_tx_dv,
  output logic [SPI_BYTE_W-1:0]         o_spi_tx_data,
  input  logic                          i_spi_done,
  input  logic                          i_spi_bytedone,
  input  logic [SPI_BYTE_W-1:0]         i_spi_rx_data
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BYTE_COUNT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTE_COUNT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arb_state_t state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, win, sel;
  logic [SPI_BYTE_W-1:0] tx_q, tx_d, rx_q, rx_d, sel_byte;
  logic ack_q, ack_d, dv_q, dv_d, pend_q, pend_d, rxv_q, rxv_d;
  logic [2:0] gidx;

  spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  // While idle the TX byte comes from the prospective winner, afterwards from the grantee.
  assign sel = (state_q == ARB_IDLE) ? win : gnt_q;
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++)
      sel_byte |= sel[k] ? i_tx_data[k*SPI_BYTE_W +: SPI_BYTE_W] : '0;
  end

  assign gidx    = onehot_to_idx(8'(gnt_q));
  assign ptr_nxt = (int'(gidx) == NUM_REQ - 1) ? '0 : PTR_W'(gidx + 3'd1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    tx_d    = tx_q;
    ack_d   = 1'b0;
    dv_d    = 1'b0;
    done_d  = '0;
    // RX byte arrives the cycle after bytedone; pend_q marks that cycle.
    pend_d  = (state_q == ARB_XFER) && i_spi_bytedone;
    rxv_d   = pend_q;
    rx_d    = pend_q ? i_spi_rx_data : rx_q;
    case (state_q)
      ARB_IDLE: if (|i_req) begin
        gnt_d   = win;
        tx_d    = sel_byte;
        ack_d   = 1'b1;
        cnt_d   = '0;
        state_d = ARB_START;
      end
      ARB_START: begin
        dv_d    = 1'b1;
        state_d = ARB_XFER;
      end
      ARB_XFER: begin
        // Reload lands one cycle ahead of the master's byte boundary.
        if (i_spi_done && cnt_q < LAST) begin
          tx_d  = sel_byte;
          ack_d = 1'b1;
        end
        if (i_spi_bytedone) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            done_d  = gnt_q;
            state_d = ARB_LAST_RX;
          end
        end
      end
      ARB_LAST_RX: begin
        ptr_d   = ptr_nxt;
        gnt_d   = '0;
        gap_d   = '0;
        state_d = ARB_GAP;
      end
      ARB_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ack_q   <= 1'b0;
      dv_q    <= 1'b0;
      pend_q  <= 1'b0;
      rxv_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ack_q   <= ack_d;
      dv_q    <= dv_d;
      pend_q  <= pend_d;
      rxv_q   <= rxv_d;
      done_q  <= done_d;
    end
  end

  assign o_gnt         = gnt_q;
  assign o_tx_ack      = ack_q;
  assign o_rx_valid    = rxv_q;
  assign o_rx_data     = rx_q;
  assign o_frame_done  = done_q;
  assign o_busy        = state_q != ARB_IDLE;
  assign o_spi_tx_dv   = dv_q;
  assign o_spi_tx_data = tx_q;
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// tb_spi_frame_arbiter: scoreboard bench for spi_frame_arbiter with a loopback SPI master model.
module tb_spi_frame_arbiter;
  localparam int NR = 4;
  localparam int BC = 5;
  localparam int GAP = 3;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [NR-1:0] i_req;
  logic [NR*8-1:0] i_tx_data;
  logic [NR-1:0] o_gnt, o_frame_done;
  logic o_tx_ack, o_rx_valid, o_busy, o_spi_tx_dv;
  logic [7:0] o_rx_data, o_spi_tx_data;
  logic i_spi_done, i_spi_bytedone;
  logic [7:0] i_spi_rx_data;

  spi_frame_arbiter #(.NUM_REQ(NR), .BYTE_COUNT(BC), .GAP_CYCLES(GAP)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_tx_data      (i_tx_data),
    .o_gnt          (o_gnt),
    .o_tx_ack       (o_tx_ack),
    .o_rx_valid     (o_rx_valid),
    .o_rx_data      (o_rx_data),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy),
    .o_spi_tx_dv    (o_spi_tx_dv),
    .o_spi_tx_data  (o_spi_tx_data),
    .i_spi_done     (i_spi_done),
    .i_spi_bytedone (i_spi_bytedone),
    .i_spi_rx_data  (i_spi_rx_data)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  int exp_gnt[$];
  int exp_fd[$];
  logic [7:0] mem [NR][256];
  logic [7:0] rd [NR] = '{default: '0};
  int queued [NR] = '{default: 0};
  int served [NR] = '{default: 0};
  logic [NR-1:0] drop = '0;
  logic spur = 1'b0;
  int ack_n = 0;
  int rx_n = 0;
  int gap_n = 0;
  logic in_gap = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always_comb begin
    i_req = '0;
    i_tx_data = '0;
    for (int r = 0; r < NR; r++) begin
      i_req[r] = (queued[r] != served[r]) && !drop[r];
      i_tx_data[r*8 +: 8] = mem[r][rd[r]];
    end
  end

  function automatic logic [39:0] pat(input int r, input int n);
    for (int j = 0; j < BC; j++) pat[39-8*j -: 8] = 8'(r*53 + n*29 + j*71 + 17);
  endfunction

  // Pushes the expectations of one frame in the order the arbiter should serve it.
  task automatic queue_frame(input int r, input logic [39:0] b);
    for (int j = 0; j < BC; j++) begin
      mem[r][queued[r]*BC + j] = b[39-8*j -: 8];
      exp_mosi.push_back(b[39-8*j -: 8]);
      exp_rx.push_back(b[39-8*j -: 8]);
    end
    exp_gnt.push_back(r);
    exp_fd.push_back(r);
    queued[r]++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && (exp_fd.size() != 0 || o_busy || in_gap); i++) @(negedge i_clk);
    check("drain", exp_fd.size(), 0);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 500 && rx_n < n; i++) @(negedge i_clk);
    check("wait_rx", rx_n >= n, 1);
  endtask

  // SPI master model: 5 cycles per byte, done one cycle before bytedone,
  // RX byte (MOSI looped back) the cycle after bytedone.
  initial begin
    int cyc, nb;
    logic act;
    logic [7:0] sh, lb;
    act = 1'b0; cyc = 0; nb = 0; sh = '0; lb = '0;
    i_spi_done = 1'b0; i_spi_bytedone = 1'b0; i_spi_rx_data = '0;
    forever begin
      @(negedge i_clk);
      i_spi_done = 1'b0;
      i_spi_bytedone = spur;
      if (i_rst) act = 1'b0;
      else if (!act) begin
        if (o_spi_tx_dv) begin act = 1'b1; cyc = 0; nb = 0; sh = o_spi_tx_data; end
      end else begin
        cyc++;
        if (cyc == 3) i_spi_done = 1'b1;
        if (cyc == 4) begin
          i_spi_bytedone = 1'b1;
          if (exp_mosi.size() == 0) check("mosi_extra", 1, 0);
          else check("mosi", sh, exp_mosi.pop_front());
          lb = sh;
          sh = o_spi_tx_data;
        end
        if (cyc == 5) begin
          i_spi_rx_data = lb;
          cyc = 0;
          nb++;
          if (nb == BC) act = 1'b0;
        end
      end
    end
  end

  // Monitor: requester byte advance, scoreboard pops, per-frame counts and gap length.
  initial begin
    int e;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        exp_gnt.delete(); exp_fd.delete(); exp_rx.delete(); exp_mosi.delete();
        for (int r = 0; r < NR; r++) begin served[r] = queued[r]; rd[r] = 8'(queued[r]*BC); end
        ack_n = 0; rx_n = 0; gap_n = 0; in_gap = 1'b0;
      end else begin
        if (o_tx_ack) begin
          ack_n++;
          for (int r = 0; r < NR; r++) if (o_gnt[r]) rd[r]++;
        end
        if (o_rx_valid) begin
          rx_n++;
          if (exp_rx.size() == 0) check("rx_extra", 1, 0);
          else check("rx", o_rx_data, exp_rx.pop_front());
        end
        if (o_spi_tx_dv) begin
          if (exp_gnt.size() == 0) check("dv_extra", 1, 0);
          else begin e = exp_gnt.pop_front(); check("gnt", o_gnt, NR'(1) << e); end
        end
        if (|o_frame_done) begin
          if (exp_fd.size() == 0) check("fd_extra", 1, 0);
          else begin e = exp_fd.pop_front(); check("frame_done", o_frame_done, NR'(1) << e); end
          check("ack_cnt", ack_n, BC);
          for (int r = 0; r < NR; r++) if (o_frame_done[r]) served[r]++;
          in_gap = 1'b1;
          gap_n = 0;
        end else if (in_gap) begin
          if (o_busy) begin
            if (o_gnt == '0) gap_n++;
          end else begin
            check("gap", gap_n, GAP);
            check("rx_cnt", rx_n, BC);
            in_gap = 1'b0; ack_n = 0; rx_n = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_outs", {o_gnt, o_tx_ack, o_rx_valid, o_rx_data, o_frame_done, o_busy, o_spi_tx_dv, o_spi_tx_data}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    // All four requesting, requester 0 twice
    @(negedge i_clk);
`ifdef SPI_ARB_FIXED_PRIO_EN
    queue_frame(0, pat(0, 0)); queue_frame(0, pat(0, 1));
    queue_frame(1, pat(1, 0)); queue_frame(2, pat(2, 0)); queue_frame(3, pat(3, 0));
`else
    queue_frame(0, pat(0, 0)); queue_frame(1, pat(1, 0)); queue_frame(2, pat(2, 0));
    queue_frame(3, pat(3, 0)); queue_frame(0, pat(0, 1));
`endif
    wait_idle();
    // Single requester with known bytes, latency checks
    @(negedge i_clk);
    queue_frame(2, 40'hA53CFF0081);
    @(negedge i_clk);
    check("gnt_early", o_gnt, 4'b0100);
    check("ack_first", o_tx_ack, 1);
    check("dv_early", o_spi_tx_dv, 0);
    check("busy", o_busy, 1);
    @(negedge i_clk);
    check("dv_lat", o_spi_tx_dv, 1);
    check("tx0", o_spi_tx_data, 8'hA5);
    wait_idle();
    // Spurious bytedone while idle
    @(negedge i_clk); spur = 1'b1;
    @(negedge i_clk); spur = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      check("spur_rxv", o_rx_valid, 0);
      check("spur_busy", o_busy, 0);
    end
    // Request 1 dropped mid-frame
    queue_frame(1, pat(1, 1));
    wait_rx(2);
    drop[1] = 1'b1;
    wait_idle();
    drop[1] = 1'b0;
    // Reset during byte 3, then a fresh frame
    @(negedge i_clk);
    queue_frame(3, pat(3, 1));
    wait_rx(2);
    i_rst = 1'b1;
    #1;
    check("rst_mid", {o_gnt, o_tx_ack, o_rx_valid, o_rx_data, o_frame_done, o_busy, o_spi_tx_dv, o_spi_tx_data}, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    queue_frame(1, pat(1, 2));
    wait_idle();
    check("q_empty", exp_mosi.size() + exp_rx.size() + exp_gnt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
